hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Keeps its own shadow scoreboard of in-flight destination registers.
- Generates PC/IF-ID stall, IF-ID/ID-EX flush and registered EX-stage forwarding selects.
- Sequences three events: load-use stall, EX-resolved redirect flush, and full-pipeline freeze on DRAM busy.

Parameters:
REG_AW, 5, register index width
CNT_W, 32, width of perf counters (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source 1 index
id_rs2  in  REG_AW  ID source 2 index
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd  in  REG_AW  ID destination index
id_rf_we  in  1  ID instruction writes RF
id_is_load  in  1  ID instruction is a load (wb source DRAM)
ex_redirect  in  1  one-cycle pulse: branch taken / JAL / JALR resolved in EX
mem_busy  in  1  DRAM access not complete; whole pipeline must hold
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID to bubble
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_stall  out  1  hold EX/MEM and MEM/WB
fwd_a_sel  out  2  EX operand A source: 00 RF, 01 EX/MEM ALU result, 10 MEM/WB write-back data
fwd_b_sel  out  2  same for operand B
state  out  2  00 RUN, 01 LDSTALL, 10 FREEZE, 11 FLUSH

Behaviour:
Reset:
- Async assert clears all shadow entries (rd=0, we=0, load=0), pending redirect, fwd_*_sel=00 and state=RUN.
- All stall/flush outputs are 0 while reset is asserted.

Shadow scoreboard:
- Three slots: EX{rd,we,load}, MEM{rd,we,load}, WB{rd,we}.
- A slot matches a source only if we=1, rd!=0 and rd==rs and the matching rsX_used=1. x0 never matches.

Priority each cycle (combinational outputs, same cycle as inputs):
1. FREEZE (mem_busy=1): pc_stall=if_id_stall=ex_mem_stall=1, no flush. Shadow and fwd selects hold. If ex_redirect=1, set the pending redirect bit.
2. FLUSH (ex_redirect=1 or pending set, mem_busy=0): if_id_flush=id_ex_flush=1, no stall. Clear pending. A simultaneous load-use hazard is ignored (wrong path).
3. LDSTALL (load-use: id_valid and EX slot load=1 and it matches rs1 or rs2): pc_stall=if_id_stall=id_ex_flush=1.
4. RUN: all 0.
- The state output is a register holding the case selected in the previous cycle.

Shadow update at a clock edge, when not frozen:
- WB<=MEM, MEM<=EX.
- EX<={id_rd,id_rf_we&id_valid,id_is_load} in RUN; EX<=bubble (all 0) on id_ex_flush.

Forwarding (registered; valid for the instruction entering EX; same update condition as shadow):
- Per operand: 01 if it matches the EX slot (non-load); 10 if it matches the MEM slot; else 00.
- The EX slot has priority over the MEM slot (youngest wins).
- Bubble/flush loads 00.
- After a load-use stall, the load sits in MEM, so the next cycle selects 10.
- WB-slot matches need no forwarding: the RF writes in the first half-cycle.

Boundaries:
- Back-to-back loads each cause at most one stall.
- Redirect during freeze is applied on the first unfrozen cycle, exactly once.
- Reset mid-stall returns to RUN with no residual flush.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt and flush_cnt (CNT_W each).
  - stall_cnt increments each LDSTALL cycle; flush_cnt increments each FLUSH cycle.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- lw x5 in EX with load=1, ID add x6,x5,x7 (rs1_used) -> one cycle pc_stall=if_id_stall=id_ex_flush=1, state=LDSTALL next cycle; following cycle fwd_a_sel=10.
- ID add x3,x1,x2 after add x1 in EX and add x2 in MEM -> next cycle fwd_a_sel=01, fwd_b_sel=10, no stall.
- ID rd=x0 write followed by a reader of x0 -> fwd_*_sel=00, no stall.
- ex_redirect pulse with a load-use hazard present -> if_id_flush=id_ex_flush=1, pc_stall=0, EX slot becomes bubble.
- mem_busy high 3 cycles, ex_redirect pulsed in the 2nd -> 3 cycles of full stall, shadow unchanged, then exactly one FLUSH cycle.
- HAZARD_PERF_EN: 2 load-use stalls plus 1 redirect -> stall_cnt=2, flush_cnt=1; rst_n low mid-sequence -> both 0 and state=RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard, stall/flush sequencing and registered EX forwarding selects.
// Optional build macro HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Handshake-free block: every input is sampled as a level each cycle; the
  // stall/flush outputs answer the same cycle, selects and state one edge later.
  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_LDSTALL = 2'b01,
    S_FREEZE  = 2'b10,
    S_FLUSH   = 2'b11
  } state_t;

  state_t state_q, cur_case;

  // The WB slot and the MEM load flag are not kept: a WB match never needs
  // forwarding, and MEM forwarding always takes write-back data.
  logic [REG_AW-1:0] ex_rd, mem_rd;
  logic              ex_we, ex_ld, mem_we;
  logic              redirect_pend;

  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, load_use;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  always_comb begin
    ex_hit_a  = ex_we  && (ex_rd  != '0) && (ex_rd  == id_rs1) && id_rs1_used;
    ex_hit_b  = ex_we  && (ex_rd  != '0) && (ex_rd  == id_rs2) && id_rs2_used;
    mem_hit_a = mem_we && (mem_rd != '0) && (mem_rd == id_rs1) && id_rs1_used;
    mem_hit_b = mem_we && (mem_rd != '0) && (mem_rd == id_rs2) && id_rs2_used;
    load_use  = id_valid && ex_ld && (ex_hit_a || ex_hit_b);
  end

  // Case selection and same-cycle control outputs.
  always_comb begin
    cur_case     = S_RUN;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    if (!rst_n)                              cur_case = S_RUN;
    else if (mem_busy)                       cur_case = S_FREEZE;
    else if (ex_redirect || redirect_pend)   cur_case = S_FLUSH;
    else if (load_use)                       cur_case = S_LDSTALL;
    case (cur_case)
      S_FREEZE: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end
      S_FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      S_LDSTALL: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Youngest producer wins; a load in EX cannot forward yet.
  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (cur_case == S_RUN) begin
      if (ex_hit_a && !ex_ld) fwd_a_nxt = 2'b01;
      else if (mem_hit_a)     fwd_a_nxt = 2'b10;
      if (ex_hit_b && !ex_ld) fwd_b_nxt = 2'b01;
      else if (mem_hit_b)     fwd_b_nxt = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      ex_rd         <= '0;
      ex_we         <= 1'b0;
      ex_ld         <= 1'b0;
      mem_rd        <= '0;
      mem_we        <= 1'b0;
      redirect_pend <= 1'b0;
      fwd_a_sel     <= 2'b00;
      fwd_b_sel     <= 2'b00;
    end else begin
      state_q <= cur_case;
      if (cur_case == S_FREEZE) begin
        if (ex_redirect) redirect_pend <= 1'b1;
      end else begin
        if (cur_case == S_FLUSH) redirect_pend <= 1'b0;
        mem_rd    <= ex_rd;
        mem_we    <= ex_we;
        fwd_a_sel <= fwd_a_nxt;
        fwd_b_sel <= fwd_b_nxt;
        if (cur_case == S_RUN) begin
          ex_rd <= id_rd;
          ex_we <= id_rf_we & id_valid;
          ex_ld <= id_is_load;
        end else begin
          ex_rd <= '0;
          ex_we <= 1'b0;
          ex_ld <= 1'b0;
        end
      end
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cur_case == S_LDSTALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (cur_case == S_FLUSH && flush_cnt != '1)   flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks plus randomized traffic against an in-bench pipeline model.
// Define HAZARD_PERF_EN to also cover the perf counters.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          id_valid, id_rs1_used, id_rs2_used, id_rf_we, id_is_load;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_redirect, mem_busy;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel, state;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural pipeline model ----------------
  // In-flight instructions as a list: index 0 = EX, 1 = MEM.
  typedef struct {
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
  } instr_t;

  instr_t     pipe [2];
  logic       m_pend;
  logic [1:0] m_fa, m_fb, m_state;
  logic [CW-1:0] m_sc, m_fc;

  function automatic logic writes(instr_t s, logic [AW-1:0] rs, logic used);
    return used && s.we && (s.rd != 0) && (s.rd == rs);
  endfunction

  function automatic logic [1:0] pick(logic [AW-1:0] rs, logic used);
    if (writes(pipe[0], rs, used) && !pipe[0].ld) return 2'd1;
    if (writes(pipe[1], rs, used)) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    logic [1:0] kind;
    logic       hz;
    logic [1:0] na, nb;
    if (!rst_n) begin
      check("rst_stall", {pc_stall, if_id_stall, ex_mem_stall}, 0);
      check("rst_flush", {if_id_flush, id_ex_flush}, 0);
      check("rst_regs", {fwd_a_sel, fwd_b_sel, state}, 0);
      for (int i = 0; i < 2; i++) pipe[i] = '{rd: '0, we: 1'b0, ld: 1'b0};
      m_pend = 0; m_fa = 0; m_fb = 0; m_state = 0; m_sc = 0; m_fc = 0;
`ifdef HAZARD_PERF_EN
      check("rst_cnt", {stall_cnt[15:0], flush_cnt[15:0]}, 0);
`endif
    end else begin
      hz = id_valid && pipe[0].ld &&
           (writes(pipe[0], id_rs1, id_rs1_used) || writes(pipe[0], id_rs2, id_rs2_used));
      if (mem_busy)                     kind = 2'd2;
      else if (ex_redirect || m_pend)   kind = 2'd3;
      else if (hz)                      kind = 2'd1;
      else                              kind = 2'd0;
      check("pc_stall",     pc_stall,     kind == 2'd2 || kind == 2'd1);
      check("if_id_stall",  if_id_stall,  kind == 2'd2 || kind == 2'd1);
      check("ex_mem_stall", ex_mem_stall, kind == 2'd2);
      check("if_id_flush",  if_id_flush,  kind == 2'd3);
      check("id_ex_flush",  id_ex_flush,  kind == 2'd3 || kind == 2'd1);
      check("fwd_a_sel", fwd_a_sel, m_fa);
      check("fwd_b_sel", fwd_b_sel, m_fb);
      check("state", state, m_state);
`ifdef HAZARD_PERF_EN
      check("stall_cnt", stall_cnt, m_sc);
      check("flush_cnt", flush_cnt, m_fc);
`endif
      // advance the model to what the coming edge must produce
      m_state = kind;
      if (kind == 2'd1 && m_sc != '1) m_sc = m_sc + 1;
      if (kind == 2'd3 && m_fc != '1) m_fc = m_fc + 1;
      if (kind == 2'd2) begin
        if (ex_redirect) m_pend = 1;
      end else begin
        if (kind == 2'd3) m_pend = 0;
        na = (kind == 2'd0) ? pick(id_rs1, id_rs1_used) : 2'd0;
        nb = (kind == 2'd0) ? pick(id_rs2, id_rs2_used) : 2'd0;
        m_fa = na; m_fb = nb;
        pipe[1] = pipe[0];
        if (kind == 2'd0) pipe[0] = '{rd: id_rd, we: id_rf_we && id_valid, ld: id_is_load};
        else              pipe[0] = '{rd: '0, we: 1'b0, ld: 1'b0};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input int rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2);
    id_rs2_used = u2; id_rd = AW'(rd); id_rf_we = we; id_is_load = ld;
  endtask

  task automatic idle;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0;
    mem_busy = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    #1 rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("lit_reset_state", state, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();

    // load-use: lw x5 then add x6,x5,x7 (done twice)
    for (int k = 0; k < 2; k++) begin
      set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
      set_id(1, 5, 1, 7, 1, 6, 1, 0);
      @(negedge clk);
      check("lit_lu_stall", {pc_stall, if_id_stall, id_ex_flush}, 3'b111);
      tick();
      @(negedge clk);
      check("lit_lu_state", state, 2'b01);
      check("lit_lu_release", pc_stall, 1'b0);
      tick(); idle();
      @(negedge clk);
      check("lit_lu_fwd_a", fwd_a_sel, 2'b10);
      tick();
    end

    // add x2 ; add x1 ; add x3,x1,x2
    set_id(1, 0, 0, 0, 0, 2, 1, 0); tick();
    set_id(1, 0, 0, 0, 0, 1, 1, 0); tick();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    @(negedge clk);
    check("lit_fwd_nostall", pc_stall, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("lit_fwd_a01", fwd_a_sel, 2'b01);
    check("lit_fwd_b10", fwd_b_sel, 2'b10);
    tick();

    // x0 destination never matches
    set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();
    set_id(1, 0, 1, 0, 1, 4, 1, 0);
    @(negedge clk);
    check("lit_x0_nostall", pc_stall, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("lit_x0_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    tick();

    // redirect overrides a load-use hazard
    set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    ex_redirect = 1;
    @(negedge clk);
    check("lit_rd_flush", {if_id_flush, id_ex_flush, pc_stall}, 3'b110);
    tick();
    ex_redirect = 0;
    @(negedge clk);
    check("lit_rd_bubble", pc_stall, 1'b0);
    check("lit_rd_state", state, 2'b11);
    tick(); idle();
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    check("lit_perf_stall", stall_cnt, 2);
    check("lit_perf_flush", flush_cnt, 1);
    tick();
`endif

    // freeze for 3 cycles, redirect in the 2nd
    set_id(1, 0, 0, 0, 0, 1, 1, 0); tick();
    set_id(1, 1, 1, 0, 0, 2, 1, 0);
    for (int c = 0; c < 3; c++) begin
      mem_busy = 1;
      ex_redirect = (c == 1);
      @(negedge clk);
      check("lit_frz_stall", {pc_stall, if_id_stall, ex_mem_stall, if_id_flush}, 4'b1110);
      tick();
    end
    mem_busy = 0; ex_redirect = 0;
    @(negedge clk);
    check("lit_frz_flush", {if_id_flush, pc_stall}, 2'b10);
    check("lit_frz_state", state, 2'b10);
    tick();
    @(negedge clk);
    check("lit_frz_once", if_id_flush, 1'b0);
    check("lit_frz_state2", state, 2'b11);
    tick();

    // reset in the middle of a load-use stall
    set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    @(negedge clk);
    check("lit_mid_stall", pc_stall, 1'b1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("lit_mid_rst", {pc_stall, id_ex_flush, state}, 4'b0000);
    tick();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    check("lit_mid_after", {if_id_flush, state}, 3'b000);
    tick();

    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      id_valid    = ($urandom_range(0, 9) != 0);
      id_rs1      = AW'($urandom_range(0, 3));
      id_rs2      = AW'($urandom_range(0, 3));
      id_rs1_used = ($urandom_range(0, 4) != 0);
      id_rs2_used = ($urandom_range(0, 1) != 0);
      id_rd       = AW'($urandom_range(0, 3));
      id_rf_we    = ($urandom_range(0, 4) != 0);
      id_is_load  = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_busy    = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
